// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave protocol FSM state type.
package ahb_pkg;

  // HTRANS encodings
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HBURST encodings (carried on the bus; this slave does not interpret them)
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // HRESP encodings
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Data-phase FSM: WAIT stalls an in-range transfer, ERR1/ERR2 form the
  // two-cycle ERROR response for out-of-range addresses.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

endpackage

// File: rtl/ahb_sp_ram.sv
// Single-port storage: synchronous write, combinational read, no reset so
// contents survive HRESETn.
module ahb_sp_ram #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int AW     = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port: commit on the rising edge when enabled.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/ahb_slave_mem.sv
// AHB-Lite memory slave: programmable wait states, two-cycle ERROR for
// addresses beyond DEPTH, read-after-write forwarding across the
// address/data phase overlap.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic              HWRITE,
  input  logic [1:0]        HTRANS,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP
);

  localparam int               RAM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0]       WS      = 3'(WAIT_STATES);
  localparam logic [ADDR_W:0]  DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [DATA_W-1:0]   r_hrdata;
  logic                r_fwd_vld;
  logic [DATA_W-1:0]   r_fwd_data;

  logic                w_can_accept;
  logic                w_accept;
  logic                w_oob;
  logic                w_ram_we;
  logic                w_rd_phase;
  logic [DATA_W-1:0]   w_ram_rdata;
  logic [DATA_W-1:0]   w_rd_data;
  logic                w_ready;
  logic                w_resp;
  logic                w_unused;

  // A new address phase is only taken while this slave is not stalling.
  assign w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) ||
                        (r_state == ST_ERR2);
  assign w_accept     = w_can_accept && HSEL && HREADY &&
                        ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign w_oob        = ({1'b0, HADDR} >= DEPTH_W);

  // Write commits only at the end of an in-range DATA cycle; a reset on
  // that same edge drops it.
  assign w_ram_we     = (r_state == ST_DATA) && r_write && HRESETn;
  assign w_rd_phase   = (r_state == ST_DATA) && !r_write;

  ahb_sp_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .i_clk   (HCLK),
    .i_we    (w_ram_we),
    .i_addr  (r_addr[RAM_AW-1:0]),
    .i_wdata (HWDATA),
    .o_rdata (w_ram_rdata)
  );

  assign w_rd_data = r_fwd_vld ? r_fwd_data : w_ram_rdata;

  // Next-state, wait counter and bus response decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready     = 1'b1;
    w_resp      = HRESP_OKAY;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (r_state == ST_ERR2) w_resp = HRESP_ERROR;
        if (w_accept) begin
          if (w_oob) begin
            w_state_nxt = ST_ERR1;
          end else if (WS != 3'd0) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WS;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_ready = 1'b0;
        if (r_cnt <= 3'd1) begin
          w_state_nxt = ST_DATA;
          w_cnt_nxt   = 3'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 3'd1;
        end
      end
      ST_ERR1: begin
        w_ready     = 1'b0;
        w_resp      = HRESP_ERROR;
        w_state_nxt = ST_ERR2;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM state and wait counter registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the accepted address phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_addr  <= '0;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_addr  <= HADDR;
      r_write <= HWRITE;
    end
  end

  // Forward write data when a read to the same word is accepted during the
  // write's DATA cycle, so the read never depends on RAM write timing.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_fwd_vld  <= 1'b0;
      r_fwd_data <= '0;
    end else if (w_accept) begin
      r_fwd_vld  <= (r_state == ST_DATA) && r_write && !HWRITE &&
                    (HADDR == r_addr);
      r_fwd_data <= HWDATA;
    end
  end

  // Hold the last returned read word between read data phases.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_hrdata <= '0;
    end else if (w_rd_phase) begin
      r_hrdata <= w_rd_data;
    end
  end

  assign HRDATA    = w_rd_phase ? w_rd_data : r_hrdata;
  assign HREADYOUT = w_ready;
  assign HRESP     = w_resp;

  // Burst type and upper address bits are not needed by the datapath.
  assign w_unused  = ^{HBURST, r_addr};

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Bench: two slaves (WAIT_STATES=1 and 0) on shared bus signals, driven by
// a pipelined master that walks transfer tables; expectations go through a
// scoreboard queue at address acceptance and are checked at data completion.
module tb_ahb_slave_mem;
  import ahb_pkg::*;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       hsel, cur;
  logic [9:0] HADDR;
  logic       HWRITE;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic [7:0] HWDATA;

  logic       sel1, sel0, rdy1, rdy0, resp1, resp0;
  logic [7:0] rd1, rd0;
  logic       rdy, resp;
  logic [7:0] rdata;

  always #5 HCLK = ~HCLK;

  assign sel1  = hsel & cur;
  assign sel0  = hsel & ~cur;
  assign rdy   = cur ? rdy1  : rdy0;
  assign resp  = cur ? resp1 : resp0;
  assign rdata = cur ? rd1   : rd0;

  ahb_slave_mem #(.ADDR_W(10), .DATA_W(8), .DEPTH(256), .WAIT_STATES(1)) u_dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel1), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(rdy1),
    .HRDATA(rd1), .HREADYOUT(rdy1), .HRESP(resp1));

  ahb_slave_mem #(.ADDR_W(10), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(rdy0),
    .HRDATA(rd0), .HREADYOUT(rdy0), .HRESP(resp0));

  typedef struct {
    logic [1:0] trans;
    logic [9:0] addr;
    logic       wr;
    logic [7:0] wdata;
    logic       exp_resp;
    logic       chk;
    logic [7:0] exp_rdata;
  } tx_t;

  tx_t        tbl[$];
  tx_t        sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_rd [2];
  bit         last_ok [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic tx_t mk(input logic [1:0] tr, input logic [9:0] a, input logic w,
                             input logic [7:0] d, input logic er, input logic [7:0] exp);
    tx_t t;
    t.trans = tr; t.addr = a; t.wr = w; t.wdata = d;
    t.exp_resp = er; t.chk = !w && !er; t.exp_rdata = exp;
    return t;
  endfunction

  // Pipelined master over tbl; ws is the expected stall for OKAY transfers.
  task automatic run_tbl(input int ws);
    int  idx = 0;
    bit  dp_v = 0;
    bit  noop = 0;
    int  waits = 0;
    bit  err_seen = 0;
    tx_t dp, e;
    int  ci = cur ? 1 : 0;
    dp = tbl[0];
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (idx >= tbl.size() && !dp_v && !noop) break;
      if (idx < tbl.size()) begin
        hsel = 1'b1; HTRANS = tbl[idx].trans; HADDR = tbl[idx].addr; HWRITE = tbl[idx].wr;
      end else begin
        hsel = 1'b0; HTRANS = HTRANS_IDLE;
      end
      HWDATA = dp_v ? dp.wdata : 8'h00;
      @(negedge HCLK);
      if (noop) begin
        chk("noop_ready", rdy, 1);
        chk("noop_resp", resp, 0);
        noop = 0;
      end
      if (!(dp_v && rdy && !dp.wr && !dp.exp_resp) && last_ok[ci])
        chk("hrdata_hold", rdata, last_rd[ci]);
      if (dp_v) begin
        if (!rdy) begin
          waits++;
          err_seen |= resp;
        end else begin
          e = sb.pop_front();
          chk($sformatf("waits_a%0d", e.addr), waits, e.exp_resp ? 1 : ws);
          chk($sformatf("resp_a%0d", e.addr), resp, e.exp_resp);
          if (e.exp_resp) chk($sformatf("err1_resp_a%0d", e.addr), err_seen, 1);
          if (e.chk) begin
            chk($sformatf("rdata_a%0d", e.addr), rdata, e.exp_rdata);
            last_rd[ci] = e.exp_rdata;
            last_ok[ci] = 1;
          end
          dp_v = 0;
        end
      end
      if (rdy && idx < tbl.size()) begin
        if (tbl[idx].trans[1]) begin
          sb.push_back(tbl[idx]);
          dp = tbl[idx]; dp_v = 1; waits = 0; err_seen = 0;
        end else begin
          noop = 1;
        end
        idx++;
      end
      @(posedge HCLK); #1;
    end
    if (idx < tbl.size() || dp_v) begin
      errors++;
      $display("FAIL run_timeout actual=%0d expected=%0d", idx, tbl.size());
    end
    hsel = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 8'h00;
    tbl.delete();
  endtask

  // Reset the slave mid-write: stage 0 = during WAIT, 1 = during DATA.
  task automatic rst_mid(input logic [9:0] a, input logic [7:0] d, input int stage);
    cur = 1'b1; hsel = 1'b1; HTRANS = HTRANS_NONSEQ; HADDR = a; HWRITE = 1'b1; HWDATA = 8'h00;
    @(posedge HCLK); #1;
    hsel = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = d;
    if (stage == 1) begin @(posedge HCLK); #1; end
    @(negedge HCLK);
    chk($sformatf("rst_pre_ready_s%0d", stage), rdy, (stage == 1) ? 1 : 0);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("rst_mid_ready", rdy, 1);
    chk("rst_mid_resp", resp, 0);
    chk("rst_mid_rdata", rdata, 0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    for (int i = 0; i < 2; i++) begin last_rd[i] = 8'h00; last_ok[i] = 1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn = 1'b0; hsel = 1'b0; cur = 1'b1; HADDR = '0; HWRITE = 1'b0;
    HTRANS = HTRANS_IDLE; HBURST = HBURST_SINGLE; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    @(negedge HCLK);
    chk("rst_ready1", rdy1, 1); chk("rst_resp1", resp1, 0); chk("rst_rdata1", rd1, 0);
    chk("rst_ready0", rdy0, 1); chk("rst_resp0", resp0, 0); chk("rst_rdata0", rd0, 0);
    HRESETn = 1'b1;
    @(posedge HCLK); #1;
    for (int i = 0; i < 2; i++) begin last_rd[i] = 8'h00; last_ok[i] = 1; end

    // WAIT_STATES=1: basic, forwarding, error and boundary cases.
    cur = 1'b1;
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd1,   1, 8'h01, 0, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd1,   0, 8'h00, 0, 8'h01));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd5,   1, 8'h05, 0, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd5,   0, 8'h00, 0, 8'h05));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd44,  1, 8'h77, 0, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd300, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd300, 1, 8'h11, 1, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd44,  0, 8'h00, 0, 8'h77));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd255, 1, 8'hA5, 0, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd255, 0, 8'h00, 0, 8'hA5));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd256, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd7,   1, 8'h09, 0, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd8,   1, 8'h0C, 0, 8'h00));
    run_tbl(1);

    // INCR4 write burst with a BUSY, then read it back as a burst.
    HBURST = HBURST_INCR4;
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd1, 1, 8'd3, 0, 8'h00));
    tbl.push_back(mk(HTRANS_SEQ,    10'd2, 1, 8'd4, 0, 8'h00));
    tbl.push_back(mk(HTRANS_BUSY,   10'd3, 1, 8'd0, 0, 8'h00));
    tbl.push_back(mk(HTRANS_SEQ,    10'd3, 1, 8'd5, 0, 8'h00));
    tbl.push_back(mk(HTRANS_SEQ,    10'd4, 1, 8'd6, 0, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd1, 0, 8'd0, 0, 8'd3));
    tbl.push_back(mk(HTRANS_SEQ,    10'd2, 0, 8'd0, 0, 8'd4));
    tbl.push_back(mk(HTRANS_SEQ,    10'd3, 0, 8'd0, 0, 8'd5));
    tbl.push_back(mk(HTRANS_SEQ,    10'd4, 0, 8'd0, 0, 8'd6));
    run_tbl(1);
    HBURST = HBURST_SINGLE;

    // Resets in the middle of writes must drop them.
    rst_mid(10'd7, 8'hAA, 0);
    rst_mid(10'd8, 8'hBB, 1);
    cur = 1'b1;
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd7, 0, 8'h00, 0, 8'h09));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd8, 0, 8'h00, 0, 8'h0C));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd44, 0, 8'h00, 0, 8'h77));
    run_tbl(1);

    // WAIT_STATES=0: back-to-back writes then reads, forwarding, error.
    cur = 1'b0;
    HBURST = HBURST_INCR;
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 10'(10 + i), 1, 8'(i * 29 + 7), 0, 8'h00));
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk((i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ, 10'(10 + i), 0, 8'h00, 0, 8'(i * 29 + 7)));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd5,   1, 8'h55, 0, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd5,   0, 8'h00, 0, 8'h55));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd300, 0, 8'h00, 1, 8'h00));
    tbl.push_back(mk(HTRANS_NONSEQ, 10'd5,   0, 8'h00, 0, 8'h55));
    run_tbl(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
